// File: rtl/prog_mem_pkg.sv
// Shared encodings for the program memory: programming commands, control states, default unlock keys.
// No logic; imported by the controller and its testbench-facing interface users.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_KEY   = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_CLEAR = 2'b11
    } pgm_cmd_e;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'b00,
        ST_KEY1_OK  = 2'b01,
        ST_UNLOCKED = 2'b10,
        ST_CLEAR    = 2'b11
    } pgm_state_e;

    localparam logic [7:0] KEY1_DEFAULT = 8'hA5;
    localparam logic [7:0] KEY2_DEFAULT = 8'h5A;

endpackage

// File: rtl/prog_mem_if.sv
// Fetch read port plus programming port of the program memory; master = fetch/programmer side.
// Read side is ready/valid with fixed latency; programming side is fire-and-forget with status flags.
interface prog_mem_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic [1:0]            pgm_cmd;
    logic [ADDR_WIDTH-1:0] pgm_addr;
    logic [DATA_WIDTH-1:0] pgm_data;
    logic                  pgm_unlocked;
    logic                  pgm_busy;
    logic                  pgm_err;

    modport master (
        output rd_req, rd_addr, pgm_cmd, pgm_addr, pgm_data,
        input  rd_ready, rd_data, rd_valid, pgm_unlocked, pgm_busy, pgm_err
    );

    modport slave (
        input  rd_req, rd_addr, pgm_cmd, pgm_addr, pgm_data,
        output rd_ready, rd_data, rd_valid, pgm_unlocked, pgm_busy, pgm_err
    );

endinterface

// File: rtl/prog_mem_rd_pipe.sv
// Read-data delay line: PIPE_STAGES registers carrying valid and data, latency PIPE_STAGES cycles.
// No backpressure; every entry advances each cycle and reset flushes all stages to zero.
module prog_mem_rd_pipe #(
    parameter int DATA_WIDTH  = 8,
    parameter int PIPE_STAGES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [PIPE_STAGES-1:0] vld_q;
    logic [DATA_WIDTH-1:0]  dat_q [PIPE_STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            dat_q[0] <= in_data;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[PIPE_STAGES-1];
    assign out_data  = dat_q[PIPE_STAGES-1];

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program memory: read-first synchronous array, key-locked programming port and bulk clear; read latency PIPE_STAGES.
// rd_ready drops only while a CLEAR sweeps the array (DEPTH cycles); programming commands are never stalled.
module prog_mem_ctrl
    import prog_mem_pkg::*;
#(
    parameter int              DATA_WIDTH  = 8,
    parameter int              ADDR_WIDTH  = 7,
    parameter int              DEPTH       = 2**ADDR_WIDTH,
    parameter int              PIPE_STAGES = 1,
    parameter                  INIT_FILE   = "",
    parameter logic [7:0]      KEY1        = KEY1_DEFAULT,
    parameter logic [7:0]      KEY2        = KEY2_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] FILL  = '0
) (
    input  logic     clk,
    input  logic     reset,
    prog_mem_if.slave bus
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
        end
    end

    pgm_state_e            state;
    pgm_cmd_e              cmd;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  rd_ready_q;
    logic                  unlocked_q;
    logic                  busy_q;
    logic                  err_q;

    logic                  rd_in_range;
    logic                  pgm_in_range;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data;

    assign cmd          = pgm_cmd_e'(bus.pgm_cmd);
    assign rd_in_range  = int'(bus.rd_addr) < DEPTH;
    assign pgm_in_range = int'(bus.pgm_addr) < DEPTH;
    assign rd_accept    = bus.rd_req && rd_ready_q;

    // Combinational array read feeds the first pipe register, giving read-first behaviour on collision.
    assign rd_word = rd_in_range ? mem[bus.rd_addr] : '0;

    assign mem_we    = (state == ST_CLEAR) ||
                       (state == ST_UNLOCKED && cmd == CMD_WRITE && pgm_in_range);
    assign mem_waddr = (state == ST_CLEAR) ? clr_cnt : bus.pgm_addr;
    assign mem_wdata = (state == ST_CLEAR) ? FILL : bus.pgm_data;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_LOCKED;
            clr_cnt    <= '0;
            rd_ready_q <= 1'b1;
            unlocked_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_LOCKED: begin
                    if (cmd == CMD_KEY && bus.pgm_data[7:0] == KEY1) begin
                        state <= ST_KEY1_OK;
                    end else if (cmd == CMD_WRITE || cmd == CMD_CLEAR) begin
                        err_q <= 1'b1;
                    end
                end
                ST_KEY1_OK: begin
                    if (cmd == CMD_KEY && bus.pgm_data[7:0] == KEY2) begin
                        state      <= ST_UNLOCKED;
                        unlocked_q <= 1'b1;
                        err_q      <= 1'b0;
                    end else if (cmd != CMD_NOP) begin
                        state <= ST_LOCKED;
                        if (cmd != CMD_KEY) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    case (cmd)
                        CMD_WRITE: begin
                            if (!pgm_in_range) begin
                                err_q <= 1'b1;
                            end
                        end
                        CMD_CLEAR: begin
                            state      <= ST_CLEAR;
                            clr_cnt    <= '0;
                            unlocked_q <= 1'b0;
                            busy_q     <= 1'b1;
                            rd_ready_q <= 1'b0;
                        end
                        CMD_KEY: begin
                            state      <= ST_LOCKED;
                            unlocked_q <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                ST_CLEAR: begin
                    if (cmd != CMD_NOP) begin
                        err_q <= 1'b1;
                    end
                    if (int'(clr_cnt) == DEPTH - 1) begin
                        state      <= ST_UNLOCKED;
                        clr_cnt    <= '0;
                        unlocked_q <= 1'b1;
                        busy_q     <= 1'b0;
                        rd_ready_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= ST_LOCKED;
            endcase
        end
    end

    prog_mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .PIPE_STAGES(PIPE_STAGES)
    ) u_rd_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_valid (rd_accept),
        .in_data  (rd_word),
        .out_valid(pipe_valid),
        .out_data (pipe_data)
    );

    assign bus.rd_valid     = pipe_valid;
    assign bus.rd_data      = pipe_data;
    assign bus.rd_ready     = rd_ready_q;
    assign bus.pgm_unlocked = unlocked_q;
    assign bus.pgm_busy     = busy_q;
    assign bus.pgm_err      = err_q;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Drives two configurations (128 words / 1 stage / FILL FF and 100 words / 2 stages / FILL 3C)
// against a transaction-level model of the memory, lock sequence and clear sweep.
module tb_prog_mem_ctrl;

    localparam logic [1:0] NOP = 2'b00, KEY = 2'b01, WR = 2'b10, CLR = 2'b11;
    localparam int M_LOCKED = 0, M_HALF = 1, M_OPEN = 2, M_CLEARING = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       req   [2];
    logic [6:0] raddr [2];
    logic [1:0] cmd   [2];
    logic [6:0] paddr [2];
    logic [7:0] pdata [2];

    logic [1:0] o_vld, o_rdy, o_unl, o_busy, o_err;
    logic [7:0] o_dat [2];

    prog_mem_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) ia ();
    prog_mem_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) ib ();

    assign ia.rd_req = req[0];   assign ib.rd_req = req[1];
    assign ia.rd_addr = raddr[0]; assign ib.rd_addr = raddr[1];
    assign ia.pgm_cmd = cmd[0];   assign ib.pgm_cmd = cmd[1];
    assign ia.pgm_addr = paddr[0]; assign ib.pgm_addr = paddr[1];
    assign ia.pgm_data = pdata[0]; assign ib.pgm_data = pdata[1];

    assign o_vld  = {ib.rd_valid, ia.rd_valid};
    assign o_rdy  = {ib.rd_ready, ia.rd_ready};
    assign o_unl  = {ib.pgm_unlocked, ia.pgm_unlocked};
    assign o_busy = {ib.pgm_busy, ia.pgm_busy};
    assign o_err  = {ib.pgm_err, ia.pgm_err};
    assign o_dat[0] = ia.rd_data;
    assign o_dat[1] = ib.rd_data;

    prog_mem_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .DEPTH(128), .PIPE_STAGES(1), .FILL(8'hFF))
        dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
    prog_mem_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .DEPTH(100), .PIPE_STAGES(2), .FILL(8'h3C))
        dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

    // Reference model: word store, lock mode, words left to clear, read history per edge.
    int         m_depth [2] = '{128, 100};
    int         m_pipe  [2] = '{1, 2};
    logic [7:0] m_fill  [2] = '{8'hFF, 8'h3C};
    logic [7:0] m_mem   [2][128];
    int         m_mode  [2];
    int         m_left  [2];
    bit         m_err   [2];
    bit         hv      [2][2];
    logic [7:0] hd      [2][2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = M_LOCKED;
            m_err[d]  = 1'b0;
            m_left[d] = 0;
            for (int k = 0; k < 2; k++) begin
                hv[d][k] = 1'b0;
                hd[d][k] = 8'h00;
            end
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit         acc;
            logic [7:0] rv;
            acc = req[d] && (m_mode[d] != M_CLEARING);
            rv  = (int'(raddr[d]) < m_depth[d]) ? m_mem[d][raddr[d]] : 8'h00;
            hv[d][1] = hv[d][0]; hd[d][1] = hd[d][0];
            hv[d][0] = acc;      hd[d][0] = rv;
            case (m_mode[d])
                M_LOCKED: begin
                    if (cmd[d] == KEY && pdata[d] == 8'hA5) m_mode[d] = M_HALF;
                    else if (cmd[d] == WR || cmd[d] == CLR) m_err[d] = 1'b1;
                end
                M_HALF: begin
                    if (cmd[d] == KEY && pdata[d] == 8'h5A) begin
                        m_mode[d] = M_OPEN;
                        m_err[d]  = 1'b0;
                    end else if (cmd[d] != NOP) begin
                        m_mode[d] = M_LOCKED;
                        if (cmd[d] != KEY) m_err[d] = 1'b1;
                    end
                end
                M_OPEN: begin
                    if (cmd[d] == WR) begin
                        if (int'(paddr[d]) < m_depth[d]) m_mem[d][paddr[d]] = pdata[d];
                        else m_err[d] = 1'b1;
                    end else if (cmd[d] == CLR) begin
                        m_mode[d] = M_CLEARING;
                        m_left[d] = m_depth[d];
                    end else if (cmd[d] == KEY) begin
                        m_mode[d] = M_LOCKED;
                    end
                end
                default: begin
                    if (cmd[d] != NOP) m_err[d] = 1'b1;
                    m_mem[d][m_depth[d] - m_left[d]] = m_fill[d];
                    m_left[d]--;
                    if (m_left[d] == 0) m_mode[d] = M_OPEN;
                end
            endcase
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int p;
            p = m_pipe[d] - 1;
            chk($sformatf("rd_ready[%0d]", d), 32'(o_rdy[d]), 32'(m_mode[d] != M_CLEARING));
            chk($sformatf("pgm_unlocked[%0d]", d), 32'(o_unl[d]), 32'(m_mode[d] == M_OPEN));
            chk($sformatf("pgm_busy[%0d]", d), 32'(o_busy[d]), 32'(m_mode[d] == M_CLEARING));
            chk($sformatf("pgm_err[%0d]", d), 32'(o_err[d]), 32'(m_err[d]));
            chk($sformatf("rd_valid[%0d]", d), 32'(o_vld[d]), 32'(hv[d][p]));
            if (hv[d][p]) chk($sformatf("rd_data[%0d]", d), 32'(o_dat[d]), 32'(hd[d][p]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; raddr[d] = '0;
            cmd[d] = NOP;  paddr[d] = '0; pdata[d] = '0;
        end
    endtask

    task automatic pgm(input int d, input logic [1:0] c, input logic [6:0] a, input logic [7:0] v);
        cmd[d] = c; paddr[d] = a; pdata[d] = v;
    endtask

    task automatic unlock_both();
        for (int d = 0; d < 2; d++) pgm(d, KEY, 7'd0, 8'h00);
        step();
        for (int d = 0; d < 2; d++) pgm(d, KEY, 7'd0, 8'hA5);
        step();
        for (int d = 0; d < 2; d++) pgm(d, KEY, 7'd0, 8'h5A);
        step();
        idle();
    endtask

    task automatic readback_all();
        for (int a = 0; a < 128; a++) begin
            req[0] = 1'b1; raddr[0] = 7'(a);
            req[1] = 1'b1; raddr[1] = 7'(a);
            step();
        end
        idle();
        step();
        step();
    endtask

    int busy_a, busy_b, nrdy_a;

    initial begin
        idle();
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 128; a++) m_mem[d][a] = 8'h00;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("reset_rd_data_a", 32'(o_dat[0]), 32'h0);
        chk("reset_rd_data_b", 32'(o_dat[1]), 32'h0);
        reset = 1'b1;

        // Initial image is all zero, back-to-back reads with no gaps
        readback_all();

        // WRITE while locked is refused and flagged
        pgm(0, WR, 7'd5, 8'h3C); pgm(1, WR, 7'd5, 8'h3C);
        step();
        idle();
        req[0] = 1'b1; raddr[0] = 7'd5; req[1] = 1'b1; raddr[1] = 7'd5;
        step();
        idle();
        step();
        step();
        unlock_both();
        step();

        // Read-first collision, then the new value; second config hits an out-of-range address
        pgm(0, WR, 7'd2, 8'h86); req[0] = 1'b1; raddr[0] = 7'd2;
        pgm(1, WR, 7'd120, 8'h86); req[1] = 1'b1; raddr[1] = 7'd120;
        step();
        cmd[0] = NOP; cmd[1] = NOP;
        raddr[1] = 7'd2;
        step();
        idle();
        step();
        step();

        // Random writes, reads and key traffic
        for (int i = 0; i < 300; i++) begin
            for (int d = 0; d < 2; d++) begin
                int r;
                r = $urandom_range(0, 99);
                req[d]   = ($urandom_range(0, 9) < 7);
                raddr[d] = 7'($urandom_range(0, 127));
                if (r < 60) pgm(d, WR, 7'($urandom_range(0, 127)), 8'($urandom));
                else if (r < 66) pgm(d, KEY, 7'd0, 8'hA5);
                else if (r < 72) pgm(d, KEY, 7'd0, 8'h5A);
                else if (r < 75) pgm(d, KEY, 7'd0, 8'($urandom));
                else pgm(d, NOP, 7'd0, 8'h00);
            end
            step();
        end
        idle();
        step();
        step();

        // Full CLEAR with a read in flight, reads attempted and a stray WRITE during the sweep
        unlock_both();
        busy_a = 0; busy_b = 0; nrdy_a = 0;
        pgm(0, CLR, 7'd0, 8'h00); pgm(1, CLR, 7'd0, 8'h00);
        req[0] = 1'b1; raddr[0] = 7'd9; req[1] = 1'b1; raddr[1] = 7'd9;
        step();
        if (o_busy[0]) busy_a++;
        if (o_busy[1]) busy_b++;
        if (!o_rdy[0]) nrdy_a++;
        for (int i = 0; i < 132; i++) begin
            cmd[0] = (i == 40) ? WR : NOP; paddr[0] = 7'd3; pdata[0] = 8'h11;
            cmd[1] = (i == 40) ? WR : NOP; paddr[1] = 7'd3; pdata[1] = 8'h11;
            req[0] = 1'b0; req[1] = 1'b0;
            if (i > 2 && i < 95) begin
                req[0] = 1'b1; raddr[0] = 7'($urandom_range(0, 127));
                req[1] = 1'b1; raddr[1] = 7'($urandom_range(0, 127));
            end
            step();
            if (o_busy[0]) busy_a++;
            if (o_busy[1]) busy_b++;
            if (!o_rdy[0]) nrdy_a++;
        end
        idle();
        chk("clear_busy_cycles_a", 32'(busy_a), 32'd128);
        chk("clear_busy_cycles_b", 32'(busy_b), 32'd100);
        chk("clear_not_ready_a", 32'(nrdy_a), 32'd128);
        readback_all();

        // Reset ten cycles into a CLEAR on the first configuration
        unlock_both();
        for (int a = 0; a < 12; a++) begin
            pgm(0, WR, 7'(a), 8'(8'h40 + a));
            step();
        end
        pgm(0, CLR, 7'd0, 8'h00);
        step();
        idle();
        repeat (10) step();
        reset = 1'b0;
        model_reset();
        #2;
        check_all();
        chk("midclear_rd_data_a", 32'(o_dat[0]), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_all();
        for (int a = 0; a < 12; a++) begin
            req[0] = 1'b1; raddr[0] = 7'(a);
            step();
        end
        idle();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
